// File: rtl/video_timing_pkg.sv
// Shared timing types and power-on defaults (640x480 @ 60 Hz) for the raster generator.
package video_timing_pkg;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } pol_e;

  // Field widths are the widest supported axis; each axis takes its low bits.
  typedef struct packed {
    logic [15:0] act;
    logic [15:0] fp;
    logic [15:0] sw;
    logic [15:0] bp;
  } timing_t;

  localparam timing_t H_DEFAULT = '{act: 16'd640, fp: 16'd16, sw: 16'd96, bp: 16'd48};
  localparam timing_t V_DEFAULT = '{act: 16'd480, fp: 16'd10, sw: 16'd2,  bp: 16'd33};
  localparam pol_e    HPOL_DEFAULT = POL_LOW;
  localparam pol_e    VPOL_DEFAULT = POL_LOW;

endpackage

// File: rtl/timing_axis.sv
// One raster axis: shadow/active timing fields, wrapping position counter and region decode.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int      W   = 11,
  parameter timing_t DEF = H_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_act,
  input  logic [W-1:0] i_fp,
  input  logic [W-1:0] i_sw,
  input  logic [W-1:0] i_bp,
  input  logic         i_apply,
  input  logic         i_hold,
  input  logic         i_step,
  output logic [W-1:0] o_pos,
  output logic         o_end,
  output logic         o_act,
  output logic         o_sync
);

  localparam int TW = W + 2;
  localparam logic [3:0][W-1:0] DEF_FIELDS =
    {DEF.bp[W-1:0], DEF.sw[W-1:0], DEF.fp[W-1:0], DEF.act[W-1:0]};

  // Field order in the packed vectors: [0] act, [1] fp, [2] sw, [3] bp.
  logic [3:0][W-1:0] cur_q, cur_d, shd_q, shd_d;
  logic [W-1:0]      pos_q, pos_d;
  logic [TW-1:0]     pos_x, sync_lo, sync_hi, tot;

  always_comb begin
    pos_x   = {2'b00, pos_q};
    sync_lo = {2'b00, cur_q[0]} + {2'b00, cur_q[1]};
    sync_hi = sync_lo + {2'b00, cur_q[2]};
    tot     = sync_hi + {2'b00, cur_q[3]};
  end

  assign o_pos  = pos_q;
  assign o_end  = (pos_x == tot - TW'(1));
  assign o_act  = (pos_x < {2'b00, cur_q[0]});
  assign o_sync = (pos_x >= sync_lo) && (pos_x < sync_hi);

  always_comb begin
    cur_d = cur_q;
    shd_d = shd_q;
    pos_d = pos_q;
    if (i_wr)    shd_d = {i_bp, i_sw, i_fp, i_act};
    // Apply reads the shadow before this cycle's write lands in it.
    if (i_apply) cur_d = shd_q;
    if (i_hold || i_apply) pos_d = '0;
    else if (i_step)       pos_d = o_end ? '0 : pos_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= DEF_FIELDS;
      shd_q <= DEF_FIELDS;
      pos_q <= '0;
    end else begin
      cur_q <= cur_d;
      shd_q <= shd_d;
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running DE/HSync/VSync raster generator with shadowed timing applied at frame boundaries.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int p_hcnt = 11,
  parameter int p_vcnt = 11
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_en,
  input  logic              i_cfg_wr,
  input  logic [p_hcnt-1:0] i_cfg_hact,
  input  logic [p_hcnt-1:0] i_cfg_hfp,
  input  logic [p_hcnt-1:0] i_cfg_hsw,
  input  logic [p_hcnt-1:0] i_cfg_hbp,
  input  logic [p_vcnt-1:0] i_cfg_vact,
  input  logic [p_vcnt-1:0] i_cfg_vfp,
  input  logic [p_vcnt-1:0] i_cfg_vsw,
  input  logic [p_vcnt-1:0] i_cfg_vbp,
  input  logic              i_cfg_hpol,
  input  logic              i_cfg_vpol,
  output logic              o1_de,
  output logic              o1_hs,
  output logic              o1_vs,
  output logic              o1_fs,
  output logic              o_cfg_pend,
  output logic              o1_cfg_err
);

  logic              cfg_ok, wr_ok, apply;
  logic [p_hcnt-1:0] h_pos;
  logic [p_vcnt-1:0] v_pos;
  logic              h_end, h_act, h_sync, v_end, v_act, v_sync;
  logic              pend_q, pend_d;
  pol_e              hpol_q, hpol_d, hpol_shd_q, hpol_shd_d;
  pol_e              vpol_q, vpol_d, vpol_shd_q, vpol_shd_d;
  logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, err_q, err_d;

  assign cfg_ok = (|i_cfg_hact) && (|i_cfg_hfp) && (|i_cfg_hsw) && (|i_cfg_hbp) &&
                  (|i_cfg_vact) && (|i_cfg_vfp) && (|i_cfg_vsw) && (|i_cfg_vbp);
  assign wr_ok  = i_cfg_wr && cfg_ok;
  // While disabled the raster sits at origin, so a pending config can switch in at once.
  assign apply  = pend_q && (!i_en || (h_end && v_end));

  timing_axis #(.W(p_hcnt), .DEF(H_DEFAULT)) u_h_axis (
    .clk(i_clk), .rst(i_res), .i_wr(wr_ok),
    .i_act(i_cfg_hact), .i_fp(i_cfg_hfp), .i_sw(i_cfg_hsw), .i_bp(i_cfg_hbp),
    .i_apply(apply), .i_hold(!i_en), .i_step(i_en),
    .o_pos(h_pos), .o_end(h_end), .o_act(h_act), .o_sync(h_sync)
  );

  timing_axis #(.W(p_vcnt), .DEF(V_DEFAULT)) u_v_axis (
    .clk(i_clk), .rst(i_res), .i_wr(wr_ok),
    .i_act(i_cfg_vact), .i_fp(i_cfg_vfp), .i_sw(i_cfg_vsw), .i_bp(i_cfg_vbp),
    .i_apply(apply), .i_hold(!i_en), .i_step(i_en && h_end),
    .o_pos(v_pos), .o_end(v_end), .o_act(v_act), .o_sync(v_sync)
  );

  always_comb begin
    pend_d     = pend_q;
    hpol_shd_d = hpol_shd_q;
    vpol_shd_d = vpol_shd_q;
    hpol_d     = hpol_q;
    vpol_d     = vpol_q;
    if (wr_ok) begin
      pend_d     = 1'b1;
      hpol_shd_d = pol_e'(i_cfg_hpol);
      vpol_shd_d = pol_e'(i_cfg_vpol);
    end else if (apply) begin
      pend_d = 1'b0;
    end
    if (apply) begin
      hpol_d = hpol_shd_q;
      vpol_d = vpol_shd_q;
    end
    de_d  = i_en && h_act && v_act;
    hs_d  = (i_en && h_sync) ? (hpol_q == POL_HIGH) : (hpol_q == POL_LOW);
    vs_d  = (i_en && v_sync) ? (vpol_q == POL_HIGH) : (vpol_q == POL_LOW);
    fs_d  = i_en && (h_pos == '0) && (v_pos == '0);
    err_d = i_cfg_wr && !cfg_ok;
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      pend_q     <= 1'b0;
      hpol_q     <= HPOL_DEFAULT;
      vpol_q     <= VPOL_DEFAULT;
      hpol_shd_q <= HPOL_DEFAULT;
      vpol_shd_q <= VPOL_DEFAULT;
      de_q       <= 1'b0;
      hs_q       <= (HPOL_DEFAULT == POL_LOW);
      vs_q       <= (VPOL_DEFAULT == POL_LOW);
      fs_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      hpol_q     <= hpol_d;
      vpol_q     <= vpol_d;
      hpol_shd_q <= hpol_shd_d;
      vpol_shd_q <= vpol_shd_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      fs_q       <= fs_d;
      err_q      <= err_d;
    end
  end

  assign o1_de      = de_q;
  assign o1_hs      = hs_q;
  assign o1_vs      = vs_q;
  assign o1_fs      = fs_q;
  assign o_cfg_pend = pend_q;
  assign o1_cfg_err = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: a raster reference model pushes expected outputs to a
// scoreboard queue as each cycle's stimulus is driven; they are popped and compared a cycle later.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst, en, wr, hpol, vpol;
  logic [10:0] hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
  logic        o1_de, o1_hs, o1_vs, o1_fs, o_cfg_pend, o1_cfg_err;

  always #5 clk = ~clk;

  video_timing_gen #(.p_hcnt(11), .p_vcnt(11)) dut (
    .i_clk(clk), .i_res(rst), .i_en(en), .i_cfg_wr(wr),
    .i_cfg_hact(hact), .i_cfg_hfp(hfp), .i_cfg_hsw(hsw), .i_cfg_hbp(hbp),
    .i_cfg_vact(vact), .i_cfg_vfp(vfp), .i_cfg_vsw(vsw), .i_cfg_vbp(vbp),
    .i_cfg_hpol(hpol), .i_cfg_vpol(vpol),
    .o1_de(o1_de), .o1_hs(o1_hs), .o1_vs(o1_vs), .o1_fs(o1_fs),
    .o_cfg_pend(o_cfg_pend), .o1_cfg_err(o1_cfg_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state; field index 0..3 = h act/fp/sw/bp, 4..7 = v act/fp/sw/bp.
  int  m_h, m_v;
  int  ca[8], sh[8];
  bit  cp[2], sp[2];
  bit  m_pend;
  int  cyc = 0;
  int  de_cnt, hs_lo_cnt, err_cnt, fs_last, fs_period;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ca = '{640, 16, 96, 48, 480, 10, 2, 33};
    sh = ca;
    cp = '{1'b0, 1'b0};
    sp = cp;
    m_h = 0;
    m_v = 0;
    m_pend = 1'b0;
    exp_q.delete();
  endtask

  function automatic bit model_endf();
    return (m_h == ca[0] + ca[1] + ca[2] + ca[3] - 1) &&
           (m_v == ca[4] + ca[5] + ca[6] + ca[7] - 1);
  endfunction

  task automatic set_cfg(input int ha, hf, hw, hb, va, vf, vw, vb, input bit hp, vp);
    hact = 11'(ha); hfp = 11'(hf); hsw = 11'(hw); hbp = 11'(hb);
    vact = 11'(va); vfp = 11'(vf); vsw = 11'(vw); vbp = 11'(vb);
    hpol = hp; vpol = vp;
  endtask

  // One clock: predict outputs from the current model state and inputs, advance the model,
  // then compare the DUT on the following falling edge.
  task automatic cycle(input string tag);
    int ht, vt;
    bit de, hsr, vsr, fs, bad, apply, hs_v, vs_v;
    logic [5:0] obs;
    ht    = ca[0] + ca[1] + ca[2] + ca[3];
    vt    = ca[4] + ca[5] + ca[6] + ca[7];
    de    = en && (m_h < ca[0]) && (m_v < ca[4]);
    hsr   = en && (m_h >= ca[0] + ca[1]) && (m_h < ca[0] + ca[1] + ca[2]);
    vsr   = en && (m_v >= ca[4] + ca[5]) && (m_v < ca[4] + ca[5] + ca[6]);
    hs_v  = hsr ? cp[0] : !cp[0];
    vs_v  = vsr ? cp[1] : !cp[1];
    fs    = en && (m_h == 0) && (m_v == 0);
    bad   = (hact == 0) || (hfp == 0) || (hsw == 0) || (hbp == 0) ||
            (vact == 0) || (vfp == 0) || (vsw == 0) || (vbp == 0);
    apply = m_pend && (!en || model_endf());
    if (!en) begin
      m_h = 0; m_v = 0;
    end else if (m_h == ht - 1) begin
      m_h = 0;
      m_v = (m_v == vt - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    if (apply) begin
      ca = sh; cp = sp; m_h = 0; m_v = 0;
    end
    if (wr && !bad) begin
      sh = '{int'(hact), int'(hfp), int'(hsw), int'(hbp),
             int'(vact), int'(vfp), int'(vsw), int'(vbp)};
      sp = '{hpol, vpol};
      m_pend = 1'b1;
    end else if (apply) begin
      m_pend = 1'b0;
    end
    exp_q.push_back({de, hs_v, vs_v, fs, wr && bad, m_pend});
    @(posedge clk);
    @(negedge clk);
    cyc++;
    obs = {o1_de, o1_hs, o1_vs, o1_fs, o1_cfg_err, o_cfg_pend};
    check($sformatf("%s@%0d de_hs_vs_fs_err_pend", tag, cyc), int'(obs), int'(exp_q.pop_front()));
    if (o1_de) de_cnt++;
    if (!o1_hs) hs_lo_cnt++;
    if (o1_cfg_err) err_cnt++;
    if (o1_fs) begin
      if (fs_last >= 0) fs_period = cyc - fs_last;
      fs_last = cyc;
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    bit found;
    rst = 1'b1; en = 1'b0; wr = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({o1_de, o1_hs, o1_vs, o1_fs, o1_cfg_err, o_cfg_pend}), 6'b011000);

    // Default 640x480 timing: one full line plus the wrap into the next.
    rst = 1'b0; en = 1'b1;
    de_cnt = 0; hs_lo_cnt = 0; err_cnt = 0; fs_last = -1; fs_period = 0;
    run(800, "dflt_line0");
    check("dflt_de_per_line", de_cnt, 640);
    check("dflt_hs_low_per_line", hs_lo_cnt, 96);
    run(900, "dflt_line1");

    // Small mode, loaded immediately by writing while disabled.
    en = 1'b0;
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    wr = 1'b1; cycle("wr_small"); wr = 1'b0;
    cycle("apply_disabled");
    en = 1'b1; de_cnt = 0; fs_last = -1; fs_period = 0;
    run(144, "small");
    check("small_fs_period", fs_period, 48);
    check("small_de_3frames", de_cnt, 36);

    // Rejected write (hsync width zero).
    err_cnt = 0; fs_period = 0;
    set_cfg(4, 1, 0, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    wr = 1'b1; cycle("reject"); wr = 1'b0;
    run(100, "after_reject");
    check("reject_err_pulses", err_cnt, 1);
    check("reject_fs_period", fs_period, 48);

    // Write landing exactly on the frame-boundary apply cycle.
    set_cfg(5, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
    wr = 1'b1; cycle("wr_b"); wr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (model_endf()) found = 1'b1;
      else cycle("seek_boundary");
    end
    check("boundary_reached", int'(found), 1);
    set_cfg(3, 2, 1, 2, 2, 2, 1, 1, 1'b1, 1'b0);
    wr = 1'b1; cycle("race_wr_c"); wr = 1'b0;
    check("race_pend_kept", int'(o_cfg_pend), 1);
    run(40, "frame_b");
    check("race_pend_cleared", int'(o_cfg_pend), 0);
    run(96, "frame_c");

    // Enable gating mid-line.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_h == 3 && m_v == 1) found = 1'b1;
      else cycle("seek_midline");
    end
    check("midline_reached", int'(found), 1);
    en = 1'b0;
    run(10, "en_low");
    en = 1'b1;
    cycle("en_rise");
    check("en_rise_de_fs", int'({o1_de, o1_fs}), 2'b11);
    run(50, "en_run");

    // Asynchronous reset between clock edges while running small-mode timing C.
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    wr = 1'b1; cycle("wr_pend"); wr = 1'b0;
    run(5, "pre_reset");
    #1 rst = 1'b1;
    #1 check("async_reset_outputs",
             int'({o1_de, o1_hs, o1_vs, o1_fs, o1_cfg_err, o_cfg_pend}), 6'b011000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    de_cnt = 0; hs_lo_cnt = 0;
    run(800, "post_reset_line0");
    check("post_reset_de_per_line", de_cnt, 640);
    check("post_reset_hs_low", hs_lo_cnt, 96);
    run(20, "post_reset_line1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
